l2_req_sched: RTL and testbench

//  Channel-level host request scheduler for the L2 stream cache. It sits between the per-channel

---
 rtl/l2_req_sched.sv | 173 +++++++++++++++++
 tb/tb_l2_req_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_sched.sv
// Round-robin host request scheduler with global and per-channel outstanding-credit limits.
// Latency: input accept to o_req_v is 1 cycle; i_rsp_v to o_rsp_v is 1 cycle.
// Backpressure: one output register, reloaded when empty or o_req_r; responses cannot be stalled.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_req_v/i_req_r/i_req_ea/i_req_sid   per-channel request inputs (i_req_r one-hot or zero)
//   o_req_v/o_req_r/o_req_ea/o_req_sid   host request (sid = {channel, local sid})
//   i_rsp_v/i_rsp_r/i_rsp_sid            host response (i_rsp_r tied high)
//   o_rsp_v/o_rsp_sid                    registered response to the demux
//   o_outst                              global outstanding count
//   o_err                                sticky credit-underflow flag
//   o_stat_issued/o_stat_stall           only when L2_REQ_SCHED_STATS_EN is defined
module l2_req_sched #(
  parameter int addr_width      = 64,
  parameter int nstrms          = 64,
  parameter int nstrms_width    = $clog2(nstrms),
  parameter int l2_nstrms       = 16,
  parameter int l2_nstrms_width = $clog2(l2_nstrms),
  parameter int channels        = nstrms / l2_nstrms,
  parameter int ch_width        = $clog2(channels),
  parameter int max_out         = 32,
  parameter int ch_max          = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [channels-1:0]                 i_req_v,
  output logic [channels-1:0]                 i_req_r,
  input  logic [channels*addr_width-1:0]      i_req_ea,
  input  logic [channels*l2_nstrms_width-1:0] i_req_sid,
  output logic                                o_req_v,
  input  logic                                o_req_r,
  output logic [addr_width-1:0]               o_req_ea,
  output logic [nstrms_width-1:0]             o_req_sid,
  input  logic                                i_rsp_v,
  output logic                                i_rsp_r,
  input  logic [nstrms_width-1:0]             i_rsp_sid,
  output logic                                o_rsp_v,
  output logic [nstrms_width-1:0]             o_rsp_sid,
  output logic [$clog2(max_out+1)-1:0]        o_outst,
  output logic                                o_err
`ifdef L2_REQ_SCHED_STATS_EN
  ,
  output logic [31:0]                         o_stat_issued,
  output logic [31:0]                         o_stat_stall
`endif
);

  localparam int GW = $clog2(max_out + 1);
  localparam int CW = $clog2(ch_max + 1);
  localparam logic [GW-1:0] G_MAX = GW'(max_out);
  localparam logic [CW-1:0] C_MAX = CW'(ch_max);

  typedef struct packed {
    logic [addr_width-1:0]   ea;
    logic [nstrms_width-1:0] sid;
  } hdr_t;

  logic                       req_v_q, req_v_d;
  hdr_t                       req_dat_q;
  logic [GW-1:0]              g_cnt_q, g_cnt_d;
  logic [CW-1:0]              ch_cnt_q [channels];
  logic [CW-1:0]              ch_cnt_d [channels];
  logic [ch_width-1:0]        rr_q, rr_d;
  logic                       rsp_v_q;
  logic [nstrms_width-1:0]    rsp_sid_q;
  logic                       err_q, err_d;

  logic [addr_width-1:0]      ea_a  [channels];
  logic [l2_nstrms_width-1:0] sid_a [channels];
  logic [channels-1:0]        elig;
  logic [ch_width-1:0]        scan_idx, win_idx, rsp_ch;
  logic                       load, found, accept, g_dec;

  // Arbitration. rr_q holds the first channel to scan, i.e. one past the last winner,
  // so channel 0 wins first out of reset. Credit checks use registered counts only.
  always_comb begin
    load     = ~req_v_q | o_req_r;
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    i_req_r  = '0;
    for (int c = 0; c < channels; c++) begin
      ea_a[c]  = i_req_ea[c*addr_width +: addr_width];
      sid_a[c] = i_req_sid[c*l2_nstrms_width +: l2_nstrms_width];
      elig[c]  = i_req_v[c] & (ch_cnt_q[c] < C_MAX) & (g_cnt_q < G_MAX);
    end
    for (int i = 0; i < channels; i++) begin
      scan_idx = rr_q + ch_width'(i);
      if (!found && elig[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
    // No handshake is offered while reset is high, since the counters would drop it.
    accept = load & found & ~reset;
    for (int c = 0; c < channels; c++) begin
      i_req_r[c] = accept & (win_idx == ch_width'(c));
    end
  end

  // Credit bookkeeping. A return against an empty counter saturates at zero and flags o_err.
  always_comb begin
    rsp_ch  = i_rsp_sid[nstrms_width-1 -: ch_width];
    g_dec   = i_rsp_v & (g_cnt_q != '0);
    g_cnt_d = g_cnt_q + GW'(accept) - GW'(g_dec);
    err_d   = err_q | (i_rsp_v & ((g_cnt_q == '0) | (ch_cnt_q[rsp_ch] == '0)));
    for (int c = 0; c < channels; c++) begin
      ch_cnt_d[c] = ch_cnt_q[c]
                  + CW'(accept & (win_idx == ch_width'(c)))
                  - CW'(i_rsp_v & (rsp_ch == ch_width'(c)) & (ch_cnt_q[c] != '0));
    end
    rr_d    = accept ? win_idx + ch_width'(1) : rr_q;
    req_v_d = accept ? 1'b1 : (o_req_r ? 1'b0 : req_v_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_v_q <= 1'b0;
      g_cnt_q <= '0;
      rr_q    <= '0;
      rsp_v_q <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < channels; c++) ch_cnt_q[c] <= '0;
    end else begin
      req_v_q <= req_v_d;
      g_cnt_q <= g_cnt_d;
      rr_q    <= rr_d;
      rsp_v_q <= i_rsp_v;
      err_q   <= err_d;
      for (int c = 0; c < channels; c++) ch_cnt_q[c] <= ch_cnt_d[c];
    end
  end

  // Payload registers carry no reset; they are qualified by their valids.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_dat_q.ea  <= ea_a[win_idx];
      req_dat_q.sid <= {win_idx, sid_a[win_idx]};
    end
    rsp_sid_q <= i_rsp_sid;
  end

  assign o_req_v   = req_v_q;
  assign o_req_ea  = req_dat_q.ea;
  assign o_req_sid = req_dat_q.sid;
  assign i_rsp_r   = 1'b1;
  assign o_rsp_v   = rsp_v_q;
  assign o_rsp_sid = rsp_sid_q;
  assign o_outst   = g_cnt_q;
  assign o_err     = err_q;

`ifdef L2_REQ_SCHED_STATS_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_q + 32'(accept);
      // A stall is a cycle where someone is asking and the output could load but no credit allows it.
      if ((|i_req_v) && load && !found && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stat_issued = issued_q;
  assign o_stat_stall  = stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_l2_req_sched.sv
// Self-checking bench for l2_req_sched with a cycle-level credit/round-robin reference model.
module tb_l2_req_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   i_req_v, i_req_r;
  logic [255:0] i_req_ea;
  logic [15:0]  i_req_sid;
  logic         o_req_v, o_req_r;
  logic [63:0]  o_req_ea;
  logic [5:0]   o_req_sid;
  logic         i_rsp_v, i_rsp_r;
  logic [5:0]   i_rsp_sid;
  logic         o_rsp_v;
  logic [5:0]   o_rsp_sid;
  logic [5:0]   o_outst;
  logic         o_err;
`ifdef L2_REQ_SCHED_STATS_EN
  logic [31:0]  o_stat_issued, o_stat_stall;
`endif

  l2_req_sched dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_ea(i_req_ea), .i_req_sid(i_req_sid),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea), .o_req_sid(o_req_sid),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid),
    .o_rsp_v(o_rsp_v), .o_rsp_sid(o_rsp_sid), .o_outst(o_outst), .o_err(o_err)
`ifdef L2_REQ_SCHED_STATS_EN
    , .o_stat_issued(o_stat_issued), .o_stat_stall(o_stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          m_g, m_ptr, m_issued, m_stall, last_win;
  int          m_ch [4];
  bit          m_ov, m_rv, m_err;
  logic [63:0] m_ea;
  logic [5:0]  m_sid, m_rsid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic rand_payload();
    for (int c = 0; c < 4; c++) begin
      i_req_ea[c*64 +: 64] = {$urandom, $urandom};
      i_req_sid[c*4 +: 4]  = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_req_v = 4'hF;
    o_req_r = 1'b1;
    i_rsp_v = 1'b0;
    #1;
    chk("rst_ready_during", i_req_r, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_req_v = 4'h0;
    m_g = 0; m_ptr = 0; m_ov = 0; m_rv = 0; m_err = 0; m_issued = 0; m_stall = 0;
    for (int c = 0; c < 4; c++) m_ch[c] = 0;
    chk("rst_o_req_v", o_req_v, 0);
    chk("rst_o_rsp_v", o_rsp_v, 0);
    chk("rst_outst", o_outst, 0);
    chk("rst_err", o_err, 0);
  endtask

  // One clock: predict the grant from the current inputs, check it, clock, then check registers.
  task automatic cyc();
    int  w, rc;
    bit  load, gz, cz;
    #1;
    load = !m_ov || o_req_r;
    w = -1;
    if (load && m_g < 32) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (w < 0 && i_req_v[c] && m_ch[c] < 16) w = c;
      end
    end
    chk("ready", i_req_r, (w >= 0) ? (64'd1 << w) : 64'd0);
    @(posedge clk);
    if (i_rsp_v) begin
      rc = int'(i_rsp_sid) / 16;
      gz = (m_g == 0);
      cz = (m_ch[rc] == 0);
      if (gz || cz) m_err = 1;
      if (!gz) m_g--;
      if (!cz) m_ch[rc]--;
    end
    if (w >= 0) begin
      m_ov  = 1;
      m_ea  = i_req_ea[w*64 +: 64];
      m_sid = 6'(w * 16 + int'(i_req_sid[w*4 +: 4]));
      m_g++;
      m_ch[w]++;
      m_ptr = (w + 1) % 4;
      m_issued++;
    end else if (o_req_r) begin
      m_ov = 0;
    end
    if ((|i_req_v) && load && w < 0) m_stall++;
    m_rv = i_rsp_v;
    m_rsid = i_rsp_sid;
    last_win = w;
    #1;
    chk("o_req_v", o_req_v, m_ov);
    if (m_ov) begin
      chk("o_req_ea", o_req_ea, m_ea);
      chk("o_req_sid", o_req_sid, m_sid);
    end
    chk("o_rsp_v", o_rsp_v, m_rv);
    if (m_rv) chk("o_rsp_sid", o_rsp_sid, m_rsid);
    chk("o_outst", o_outst, m_g);
    chk("o_err", o_err, m_err);
    chk("i_rsp_r", i_rsp_r, 1);
  endtask

  initial begin
    int cnt;
    logic [63:0] held_ea;
    i_req_ea = '0; i_req_sid = '0; i_rsp_sid = '0;
    do_reset();

    // All channels requesting, host always ready: 32 grants in strict rotation, then full.
    i_req_v = 4'hF;
    for (int k = 0; k < 40; k++) begin
      rand_payload();
      cyc();
      chk("s1_winner", last_win, (k < 32) ? (k % 4) : -1);
    end
    chk("s1_outst_full", o_outst, 32);
`ifdef L2_REQ_SCHED_STATS_EN
    chk("s1_stat_issued", o_stat_issued, 32);
    chk("s1_stat_stall", o_stat_stall, 8);
`endif

    // Full, response arrives with everyone valid: no grant this cycle, grant the next.
    i_rsp_v = 1'b1; i_rsp_sid = 6'h01;
    cyc();
    chk("s4_no_grant", last_win, -1);
    chk("s4_outst_31", o_outst, 31);
    i_rsp_v = 1'b0;
    cyc();
    chk("s4_grant_ch0", last_win, 0);
    chk("s4_outst_32", o_outst, 32);

    // Single channel: limited by its own credit.
    do_reset();
    i_req_v = 4'b0100;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      rand_payload();
      cyc();
      if (last_win == 2) cnt++;
    end
    chk("s2_accepts", cnt, 16);
    chk("s2_ready_low", i_req_r, 4'h0);
    i_rsp_v = 1'b1; i_rsp_sid = 6'h25;
    cyc();
    chk("s2_rsp_cycle", last_win, -1);
    i_rsp_v = 1'b0;
    cyc();
    chk("s2_regrant", last_win, 2);

    // Host stall: held request stays put while inputs keep changing.
    do_reset();
    i_req_v = 4'hF; o_req_r = 1'b0;
    rand_payload();
    held_ea = i_req_ea[63:0];
    cyc();
    chk("s3_first", last_win, 0);
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      cyc();
      chk("s3_hold_nogrant", last_win, -1);
      chk("s3_hold_ea", o_req_ea, held_ea);
    end
    o_req_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_payload();
      cyc();
      chk("s3_b2b", last_win, (k + 1) % 4);
    end
    o_req_r = 1'b0;
    cyc();

    // Underflow: response with nothing outstanding (reset also drops the held request above).
    do_reset();
    i_rsp_v = 1'b1; i_rsp_sid = 6'($urandom_range(0, 63));
    cyc();
    chk("s5_err_set", o_err, 1);
    chk("s5_outst_zero", o_outst, 0);
    chk("s5_rsp_pulse", o_rsp_v, 1);
    i_rsp_v = 1'b0;
    cyc();
    chk("s5_rsp_once", o_rsp_v, 0);
    chk("s5_err_sticky", o_err, 1);
    do_reset();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      int rc;
      rand_payload();
      i_req_v = 4'($urandom);
      o_req_r = ($urandom_range(0, 3) != 0);
      i_rsp_v = 1'b0;
      if ($urandom_range(0, 63) == 0) begin
        i_rsp_v = 1'b1;
        i_rsp_sid = 6'($urandom_range(0, 63));
      end else if ($urandom_range(0, 1) == 1) begin
        rc = $urandom_range(0, 3);
        for (int t = 0; t < 4; t++) begin
          if (!i_rsp_v && m_ch[(rc + t) % 4] > 0) begin
            i_rsp_v = 1'b1;
            i_rsp_sid = 6'(((rc + t) % 4) * 16 + $urandom_range(0, 15));
          end
        end
      end
      cyc();
    end
`ifdef L2_REQ_SCHED_STATS_EN
    chk("rnd_stat_issued", o_stat_issued, m_issued);
    chk("rnd_stat_stall", o_stat_stall, m_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
